data_mem_bridge: RTL and testbench

Data-memory bridge that sits directly downstream of the multi-cycle CPU core's memory access port. It accepts the core's single-beat access (address from F, write data from the B/C mux, write strobe) and converts it into a valid/ready bus transaction. It returns registered read data with a one-cycle completion pulse and reports misaligned, bus-error and timeout faults. The controller stalls its memory state on `cpu_busy` and advances on `cpu_done`.

---
 rtl/mem_bridge_pkg.sv | 16 +
 rtl/bus_timeout_counter.sv | 30 +++
 rtl/data_mem_bridge.sv | 119 +++++++++++
 tb/tb_data_mem_bridge.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types for the data-memory bridge.
// State encoding and fault codes used by the bridge and its bench.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } mb_state_e;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ALIGN   = 2'b01;
    localparam logic [1:0] FLT_BUSERR  = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT = 2'b11;

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter for an outstanding bus beat.
// Flags the last allowed wait cycle while still counting.
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/data_mem_bridge.sv
// Converts single-beat core memory accesses into valid/ready bus beats,
// with registered read data and misaligned/bus-error/timeout faults.
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic              cpu_fault,
    output logic [1:0]        fault_code,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    mb_state_e state_q, state_d;
    logic      misaligned;
    logic      tmo_clear;
    logic      tmo_enable;
    logic      tmo_expired;

    assign misaligned = |cpu_addr[1:0];
    assign tmo_clear  = (state_q == IDLE);
    assign tmo_enable = (state_q == BUS) && !bus_ready;

    bus_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A ready on the expiring edge takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = misaligned ? DONE : BUS;
                end
            end
            BUS: begin
                if (bus_ready || tmo_expired) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            cpu_rdata  <= '0;
            cpu_fault  <= 1'b0;
            fault_code <= FLT_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        bus_we     <= cpu_we;
                        bus_addr   <= cpu_addr;
                        bus_wdata  <= cpu_wdata;
                        cpu_fault  <= misaligned;
                        fault_code <= misaligned ? FLT_ALIGN : FLT_NONE;
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        if (bus_err) begin
                            cpu_fault  <= 1'b1;
                            fault_code <= FLT_BUSERR;
                        end else if (!bus_we) begin
                            cpu_rdata <= bus_rdata;
                        end
                    end else if (tmo_expired) begin
                        cpu_fault  <= 1'b1;
                        fault_code <= FLT_TIMEOUT;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign bus_valid = (state_q == BUS);
    assign cpu_done  = (state_q == DONE);
    assign cpu_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge with TIMEOUT=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;
    logic        cpu_fault;
    logic [1:0]  fault_code;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    data_mem_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_busy  (cpu_busy),
        .cpu_fault (cpu_fault),
        .fault_code(fault_code),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        #12;
        checks++;
        if ({bus_valid, cpu_done, cpu_busy, cpu_fault, fault_code} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000000",
                     {bus_valid, cpu_done, cpu_busy, cpu_fault, fault_code});
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 00000000", cpu_rdata);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_zero_wait_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        tick;
        cpu_req = 1'b0;
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== 32'h100 || cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL zw_issue got v=%b a=%h d=%b want v=1 a=100 d=0",
                     bus_valid, bus_addr, cpu_done);
        end
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick;
        bus_ready = 1'b0; bus_rdata = '0;
        checks++;
        if (cpu_done !== 1'b1 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL zw_done got d=%b v=%b want d=1 v=0", cpu_done, bus_valid);
        end
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF || fault_code !== 2'b00 || cpu_fault !== 1'b0) begin
            errors++;
            $display("FAIL zw_data got %h f=%b c=%b want deadbeef f=0 c=00",
                     cpu_rdata, cpu_fault, fault_code);
        end
        tick;
        checks++;
        if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL zw_idle got d=%b b=%b want d=0 b=0", cpu_done, cpu_busy);
        end
    endtask

    task automatic test_write_wait;
        bit stable = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
        tick;
        cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!(bus_valid === 1'b1 && bus_we === 1'b1 && bus_addr === 32'h20 &&
                  bus_wdata === 32'h12345678 && cpu_done === 1'b0)) stable = 1'b0;
            tick;
        end
        bus_ready = 1'b1;
        if (!(bus_valid === 1'b1 && bus_addr === 32'h20 &&
              bus_wdata === 32'h12345678)) stable = 1'b0;
        tick;
        bus_ready = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL wr_stable got %b want 1", stable);
        end
        checks++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || fault_code !== 2'b00) begin
            errors++;
            $display("FAIL wr_done got d=%b r=%h c=%b want d=1 r=deadbeef c=00",
                     cpu_done, cpu_rdata, fault_code);
        end
        tick;
    endtask

    task automatic test_misaligned;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h102;
        tick;
        cpu_req = 1'b0;
        checks++;
        if (cpu_done !== 1'b1 || bus_valid !== 1'b0 || cpu_fault !== 1'b1 ||
            fault_code !== 2'b01) begin
            errors++;
            $display("FAIL mis_done got d=%b v=%b f=%b c=%b want d=1 v=0 f=1 c=01",
                     cpu_done, bus_valid, cpu_fault, fault_code);
        end
        tick;
        checks++;
        if (bus_valid !== 1'b0 || cpu_busy !== 1'b0 || cpu_fault !== 1'b1) begin
            errors++;
            $display("FAIL mis_after got v=%b b=%b f=%b want v=0 b=0 f=1",
                     bus_valid, cpu_busy, cpu_fault);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'h55;
        tick;
        cpu_req = 1'b0;
        checks++;
        if (cpu_fault !== 1'b0 || fault_code !== 2'b00 || bus_valid !== 1'b1) begin
            errors++;
            $display("FAIL mis_clear got f=%b c=%b v=%b want f=0 c=00 v=1",
                     cpu_fault, fault_code, bus_valid);
        end
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        tick;
    endtask

    task automatic test_bus_error;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        tick;
        cpu_req = 1'b0;
        bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 32'hBAD0BAD0;
        tick;
        bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        checks++;
        if (cpu_done !== 1'b1 || cpu_fault !== 1'b1 || fault_code !== 2'b10) begin
            errors++;
            $display("FAIL berr_code got d=%b f=%b c=%b want d=1 f=1 c=10",
                     cpu_done, cpu_fault, fault_code);
        end
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL berr_rdata got %h want deadbeef", cpu_rdata);
        end
        tick;
    endtask

    task automatic test_timeout;
        int n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        tick;
        cpu_req = 1'b0;
        while (bus_valid === 1'b1 && n < 10) begin
            n++;
            tick;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL tmo_len got %0d want 4", n);
        end
        checks++;
        if (cpu_done !== 1'b1 || cpu_fault !== 1'b1 || fault_code !== 2'b11) begin
            errors++;
            $display("FAIL tmo_code got d=%b f=%b c=%b want d=1 f=1 c=11",
                     cpu_done, cpu_fault, fault_code);
        end
        tick;
        cpu_req = 1'b1; cpu_addr = 32'h84;
        tick;
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        checks++;
        if (bus_valid !== 1'b1 || cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_edge_wait got v=%b d=%b want v=1 d=0", bus_valid, cpu_done);
        end
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        tick;
        bus_ready = 1'b0; bus_rdata = '0;
        checks++;
        if (cpu_done !== 1'b1 || fault_code !== 2'b00 || cpu_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL tmo_edge_ready got d=%b c=%b r=%h want d=1 c=00 r=0badf00d",
                     cpu_done, fault_code, cpu_rdata);
        end
        tick;
    endtask

    task automatic test_reset_mid_bus;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h88;
        tick;
        cpu_req = 1'b0;
        tick;
        cpu_req = 1'b1; cpu_addr = 32'h8C;
        tick;
        cpu_req = 1'b0;
        checks++;
        if (bus_addr !== 32'h88 || bus_valid !== 1'b1 || cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_req got a=%h v=%b d=%b want a=88 v=1 d=0",
                     bus_addr, bus_valid, cpu_done);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_valid, cpu_busy, cpu_done, cpu_fault, fault_code} !== 6'b0) begin
            errors++;
            $display("FAIL rst_bus_ctl got %b want 000000",
                     {bus_valid, cpu_busy, cpu_done, cpu_fault, fault_code});
        end
        checks++;
        if (cpu_rdata !== 32'h0 || bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_bus_data got r=%h a=%h want 0 0", cpu_rdata, bus_addr);
        end
        tick;
        rst = 1'b1;
        tick;
        checks++;
        if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after got d=%b b=%b want d=0 b=0", cpu_done, cpu_busy);
        end
    endtask

    initial begin
        test_reset;
        test_zero_wait_read;
        test_write_wait;
        test_misaligned;
        test_bus_error;
        test_timeout;
        test_reset_mid_bus;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
